// File: rtl/updown_seq_pkg.sv
// Shared encodings for the up/down sequencer: FSM state codes and sweep modes.
package updown_seq_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] UP_ST   = 2'd1;
  localparam logic [1:0] DOWN_ST = 2'd2;
  localparam logic [1:0] DONE_ST = 2'd3;

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_PP   = 2'd2;

endpackage

// File: rtl/seq_counter_core.sv
// Loadable up/down counter. The sequencer decides when to load or step,
// so this block never wraps on its own initiative.
module seq_counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] out
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    out <= '0;
    else if (load) out <= load_val;
    else if (en)   out <= dir ? out + 1'b1 : out - 1'b1;
  end

endmodule

// File: rtl/updown_sequencer.sv
// Sequencer FSM for the up/down counter: single up/down sweeps or a ping-pong
// sweep with a programmed number of reversals, plus busy/done/err status.
module updown_sequencer
  import updown_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int BW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [BW-1:0]    bounces,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] out,
  output logic             updown,
  output logic             busy,
  output logic             done,
  output logic             err
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] lo_q, hi_q;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             updown_q, updown_d;
  logic             err_q, err_d;
  logic             latch_bounds;
  logic             ld, en, dir;
  logic [WIDTH-1:0] ld_val;

  seq_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (ld),
    .load_val (ld_val),
    .en       (en),
    .dir      (dir),
    .out      (out)
  );

  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    updown_d     = updown_q;
    err_d        = 1'b0;
    latch_bounds = 1'b0;
    ld           = 1'b0;
    ld_val       = '0;
    en           = 1'b0;
    dir          = 1'b1;
    case (state_q)
      IDLE: if (start) begin
        if (lo > hi || mode == 2'd3) begin
          err_d = 1'b1;
        end else begin
          latch_bounds = 1'b1;
          ld           = 1'b1;
          ld_val       = (mode == MODE_DOWN) ? hi : lo;
          updown_d     = (mode != MODE_DOWN);
          state_d      = (mode == MODE_DOWN) ? DOWN_ST : UP_ST;
          // Non-pingpong modes get zero reversals, so they never bounce.
          bcnt_d       = (mode == MODE_PP) ? bounces : '0;
        end
      end
      UP_ST: if (abort) begin
        state_d = IDLE;
      end else if (!pause) begin
        if (out != hi_q) begin
          en = 1'b1;
        end else if (bcnt_q != '0 && lo_q != hi_q) begin
          en       = 1'b1;
          dir      = 1'b0;
          updown_d = 1'b0;
          bcnt_d   = bcnt_q - 1'b1;
          state_d  = DOWN_ST;
        end else begin
          state_d = DONE_ST;
        end
      end
      DOWN_ST: if (abort) begin
        state_d = IDLE;
      end else if (!pause) begin
        if (out != lo_q) begin
          en  = 1'b1;
          dir = 1'b0;
        end else if (bcnt_q != '0 && lo_q != hi_q) begin
          en       = 1'b1;
          updown_d = 1'b1;
          bcnt_d   = bcnt_q - 1'b1;
          state_d  = UP_ST;
        end else begin
          state_d = DONE_ST;
        end
      end
      DONE_ST: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      bcnt_q   <= '0;
      updown_q <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      updown_q <= updown_d;
      err_q    <= err_d;
      if (latch_bounds) begin
        lo_q <= lo;
        hi_q <= hi;
      end
    end
  end

  assign updown = updown_q;
  assign busy   = (state_q == UP_ST) || (state_q == DOWN_ST);
  assign done   = (state_q == DONE_ST);
  assign err    = err_q;

endmodule
